// File: rtl/alu_pipe.sv
// alu_pipe: two-stage saturating ALU; op 12 (rotate right) exists only when ALU_PIPE_ROR_EN is defined.
// Latency 2 cycles; a stalled output holds both stages and keeps the result and flags stable.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    output logic [2:0]       out_fwe,
    output logic             out_err
);
    localparam int SHW = $clog2(WIDTH);
    localparam int H   = WIDTH / 2;
    localparam int LW  = WIDTH / LANES;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_PADD = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_LHB  = 4'd10;
    localparam logic [3:0] OP_LLB  = 4'd11;
`ifdef ALU_PIPE_ROR_EN
    localparam logic [3:0] OP_ROR  = 4'd12;
`endif

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic             advance;

    // Output stage frees up when empty or being drained; S1 can then move into it.
    assign advance   = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | advance;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op;
                s1_a  <= a;
                s1_b  <= b;
            end
        end
    end

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] padd;
    logic [LW-1:0]    la;
    logic [LW-1:0]    lb;
    logic [LW-1:0]    ls;
    logic [WIDTH-1:0] res;
    logic             res_v;
    logic [2:0]       res_fwe;
    logic             res_err;
`ifdef ALU_PIPE_ROR_EN
    logic [2*WIDTH-1:0] rot;
    assign rot = {s1_a, s1_a} >> sh;
`endif

    assign sh      = s1_b[SHW-1:0];
    assign sum     = s1_a + s1_b;
    assign diff    = s1_a - s1_b;
    assign add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    assign sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);

    // Lane-wise saturating add: each lane clamps on its own, no carries cross lanes.
    always_comb begin
        padd = '0;
        la   = '0;
        lb   = '0;
        ls   = '0;
        for (int i = 0; i < LANES; i++) begin
            la = s1_a[i*LW +: LW];
            lb = s1_b[i*LW +: LW];
            ls = la + lb;
            if ((la[LW-1] == lb[LW-1]) && (ls[LW-1] != la[LW-1]))
                ls = la[LW-1] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
            padd[i*LW +: LW] = ls;
        end
    end

    always_comb begin
        res     = '0;
        res_v   = 1'b0;
        res_fwe = 3'b000;
        res_err = 1'b0;
        case (s1_op)
            OP_ADD: begin
                res     = add_ovf ? (s1_a[WIDTH-1] ? MIN_NEG : MAX_POS) : sum;
                res_v   = add_ovf;
                res_fwe = 3'b111;
            end
            OP_SUB: begin
                res     = sub_ovf ? (s1_a[WIDTH-1] ? MIN_NEG : MAX_POS) : diff;
                res_v   = sub_ovf;
                res_fwe = 3'b111;
            end
            OP_PADD: res = padd;
            OP_NAND: begin res = ~(s1_a & s1_b); res_fwe = 3'b110; end
            OP_XOR:  begin res = s1_a ^ s1_b;    res_fwe = 3'b110; end
            OP_SLL:  begin res = s1_a << sh;     res_fwe = 3'b110; end
            OP_SRL:  begin res = s1_a >> sh;     res_fwe = 3'b110; end
            OP_SRA:  begin res = $unsigned($signed(s1_a) >>> sh); res_fwe = 3'b110; end
            OP_LW, OP_SW: res = sum;
            OP_LHB: res = {s1_b[H-1:0], s1_a[H-1:0]};
            OP_LLB: res = {{(WIDTH-H){s1_b[H-1]}}, s1_b[H-1:0]};
`ifdef ALU_PIPE_ROR_EN
            OP_ROR: begin res = rot[WIDTH-1:0]; res_fwe = 3'b110; end
`endif
            default: res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out      <= '0;
            out_z    <= 1'b0;
            out_n    <= 1'b0;
            out_v    <= 1'b0;
            out_fwe  <= 3'b000;
            out_err  <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out     <= res;
                out_z   <= (res == '0);
                out_n   <= res[WIDTH-1];
                out_v   <= res_v;
                out_fwe <= res_fwe;
                out_err <= res_err;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=16, LANES=2); expectations follow ALU_PIPE_ROR_EN.
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        out_z;
    logic        out_n;
    logic        out_v;
    logic [2:0]  out_fwe;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    alu_pipe #(.WIDTH(16), .LANES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_z(out_z), .out_n(out_n), .out_v(out_v),
        .out_fwe(out_fwe), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Flags packed as {err, fwe[2:0], z, n, v}.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] e_out, input logic [6:0] e_fl);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_lat2"}, out_valid, 1);
        check({tag, "_out"}, out, e_out);
        check({tag, "_flags"}, {out_err, out_fwe, out_z, out_n, out_v}, e_fl);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] exp_q[$];
        int rcv;
        int first_cyc;
        int stale;

        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_out", out, 0);
        check("reset_flags", {out_err, out_fwe, out_z, out_n, out_v}, 0);
        check("reset_rdy", in_ready, 1);
        @(posedge clk); #1;

        run_op("add_sat_pos", 4'd0,  16'h7FFF, 16'h0001, 16'h7FFF, 7'b0_111_001);
        run_op("add_sat_neg", 4'd0,  16'h8000, 16'hFFFF, 16'h8000, 7'b0_111_011);
        run_op("add_plain",   4'd0,  16'h0003, 16'h0004, 16'h0007, 7'b0_111_000);
        run_op("sub_sat_neg", 4'd2,  16'h8000, 16'h0001, 16'h8000, 7'b0_111_011);
        run_op("sub_sat_pos", 4'd2,  16'h7FFF, 16'hFFFF, 16'h7FFF, 7'b0_111_001);
        run_op("sub_zero",    4'd2,  16'h0005, 16'h0005, 16'h0000, 7'b0_111_100);
        run_op("padd_sat",    4'd1,  16'h7F80, 16'h0180, 16'h7F80, 7'b0_000_000);
        run_op("padd_plain",  4'd1,  16'h0102, 16'h0304, 16'h0406, 7'b0_000_000);
        run_op("nand",        4'd3,  16'hFFFF, 16'hFFFF, 16'h0000, 7'b0_110_100);
        run_op("xor",         4'd4,  16'hF0F0, 16'h0FF0, 16'hFF00, 7'b0_110_010);
        run_op("sll_mask",    4'd5,  16'h00F0, 16'h0014, 16'h0F00, 7'b0_110_000);
        run_op("srl",         4'd6,  16'h8000, 16'h0004, 16'h0800, 7'b0_110_000);
        run_op("sra",         4'd7,  16'h8000, 16'h0004, 16'hF800, 7'b0_110_010);
        run_op("sra_zero",    4'd7,  16'h1234, 16'h0000, 16'h1234, 7'b0_110_000);
        run_op("lw_wrap",     4'd8,  16'h7FFF, 16'h0001, 16'h8000, 7'b0_000_010);
        run_op("sw_wrap",     4'd9,  16'hFFFF, 16'h0002, 16'h0001, 7'b0_000_000);
        run_op("lhb",         4'd10, 16'h1234, 16'h00AB, 16'hAB34, 7'b0_000_010);
        run_op("llb",         4'd11, 16'h0000, 16'h0080, 16'hFF80, 7'b0_000_010);
`ifdef ALU_PIPE_ROR_EN
        run_op("ror",         4'd12, 16'h8001, 16'h0001, 16'hC000, 7'b0_110_010);
`else
        run_op("op12_illegal",4'd12, 16'h8001, 16'h0001, 16'h0000, 7'b1_000_100);
`endif
        run_op("op15_illegal",4'd15, 16'h1234, 16'h5678, 16'h0000, 7'b1_000_100);

        // Backpressure: two accepts fill the pipe, the third waits; results drain in order.
        out_ready = 1'b0;
        op = 4'd0; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        @(posedge clk); #1 op = 4'd4; a = 16'h00FF; b = 16'h0F0F;
        @(negedge clk);
        check("stall_rdy2", in_ready, 1);
        @(posedge clk); #1 op = 4'd10; a = 16'h1234; b = 16'h00AB;
        @(negedge clk);
        check("stall_rdy3", in_ready, 0);
        check("stall_valid", out_valid, 1);
        check("stall_out", out, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_hold_out", out, 16'h0002);
            check("stall_hold_flags", {out_err, out_fwe, out_z, out_n, out_v}, 7'b0_111_000);
            check("stall_hold_rdy", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("release_rdy", in_ready, 1);
        check("release_out_a", out, 16'h0002);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("release_out_b", out, 16'h0FF0);
        check("release_valid_b", out_valid, 1);
        @(posedge clk);
        @(negedge clk);
        check("release_out_c", out, 16'hAB34);
        check("release_valid_c", out_valid, 1);
        @(posedge clk);
        @(negedge clk);
        check("release_drained", out_valid, 0);
        @(posedge clk); #1;

        // Full throughput: one op per cycle, results in order, first after two cycles.
        rcv = 0;
        first_cyc = -1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc < 4) begin
                in_valid = 1'b1; op = 4'd0; a = 16'(cyc * 3); b = 16'h0010;
                exp_q.push_back(16'(cyc * 3 + 16));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc < 4) check("tp_rdy", in_ready, 1);
            if (out_valid) begin
                rcv++;
                if (first_cyc < 0) first_cyc = cyc;
                if (exp_q.size() > 0) check("tp_out", out, exp_q.pop_front());
            end
            @(posedge clk); #1;
        end
        check("tp_count", rcv, 4);
        check("tp_first_cycle", first_cyc, 2);

        // Reset with both stages full discards everything in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0002;
        @(posedge clk); #1 a = 16'h0003; b = 16'h0004;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("rst_full_rdy", in_ready, 0);
        check("rst_full_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_out", out, 0);
        check("rst_mid_flags", {out_err, out_fwe, out_z, out_n, out_v}, 0);
        check("rst_mid_rdy", in_ready, 1);
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_no_stale", stale, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16: datapath width; even, >= 4.
REQ-002 Parameter LANES, default 2: packed-add lane count; WIDTH % LANES == 0, lane width >= 2.
REQ-003 Derived SHW = clog2(WIDTH), H = WIDTH/2.
REQ-004 One clock; reset is synchronous and active-high: clk input 1, rising-edge clock.
REQ-005 rst input 1, synchronous active-high reset.
REQ-006 in_valid input 1, operation offered.
REQ-007 in_ready output 1, operation accepted when in_valid & in_ready.
REQ-008 op input 4, opcode.
REQ-009 a, b input WIDTH, operands.
REQ-010 out_valid output 1, result available.
REQ-011 out_ready input 1, consumer accepts when out_valid & out_ready.
REQ-012 out output WIDTH, result.
REQ-013 out_z, out_n, out_v output 1 each, flags for this result.
REQ-014 out_fwe output 3, flag write enables {Z,N,V}.
REQ-015 out_err output 1, illegal opcode marker.

Function
REQ-016 Opcodes: 0 ADD sat, 1 PADD lane-sat, 2 SUB sat, 3 NAND, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 LW addr, 9 SW addr, 10 LHB, 11 LLB, 12 ROR (config), others illegal.
REQ-017 ADD/SUB: two's-complement signed; on overflow clamp to max positive/min negative; out_v=1 iff clamped.
REQ-018 PADD: each WIDTH/LANES lane saturating signed add, no carry between lanes; out_v=0.
REQ-019 Shifts use b[SHW-1:0]; SRA fills with a[WIDTH-1]; shift 0 passes a.
REQ-020 LW/SW: wrapping (non-saturating) a+b, out_v=0.
REQ-021 LHB: out = {b[H-1:0], a[H-1:0]}; LLB: out = sign-extended b[H-1:0].
REQ-022 out_z = (out==0); out_n = out[WIDTH-1].
REQ-023 out_fwe: ADD/SUB 3'b111; XOR, NAND, shifts, ROR 3'b110; all others 3'b000.
REQ-024 Illegal op: out=0, out_fwe=0, out_err=1, still occupies a slot and is delivered in order.
REQ-025 Two-stage pipeline: S1 registers op/a/b on accept; S2 registers computed result; latency exactly 2 cycles with out_ready held high.
REQ-026 S2 advances when ~s2_valid | out_ready; S1 advances into S2 under same condition.
REQ-027 in_ready = ~s1_valid | (~s2_valid | out_ready); combinational, no dependence on in_valid.
REQ-028 Full throughput: one op per cycle while out_ready=1; results in acceptance order, none dropped or duplicated.
REQ-029 While out_valid & ~out_ready, out and all flags SHALL hold stable.
REQ-030 Simultaneous accept and deliver in one cycle SHALL both occur.

Reset
REQ-031 rst SHALL clear s1_valid, s2_valid; out_valid=0, out=0, flags=0, out_fwe=0, out_err=0 on the next edge.
REQ-032 rst mid-operation discards all in-flight ops; in_ready=1 the cycle after reset deasserts.

Configuration
REQ-033 Macro ALU_PIPE_ROR_EN: defined -> op 12 rotates a right by b[SHW-1:0]; undefined -> op 12 treated as illegal per REQ-024.

Verification
REQ-034 ADD a=0x7FFF b=0x0001 -> out=0x7FFF, v=1, n=0, fwe=111, 2 cycles after accept.
REQ-035 PADD a=0x7F80 b=0x0180 (LANES=2) -> out=0x7F80, v=0, fwe=000.
REQ-036 SRA a=0x8000 b=0x0004 -> 0xF800, n=1; LLB b=0x0080 -> 0xFF80; LHB a=0x1234 b=0x00AB -> 0xAB34.
REQ-037 Three back-to-back ops with out_ready=0 -> in_ready drops after 2 accepts; release out_ready -> three results in order, stable while stalled.
REQ-038 op=12 a=0x8001 b=1 -> 0xC000 with ALU_PIPE_ROR_EN; out_err=1, out=0 without.
REQ-039 rst asserted with both stages full -> next cycle out_valid=0, no stale result emitted afterwards.
